// File: rtl/scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder_pkg
// Description : Shared definitions for the scan decoder family: FSM state
//               encodings, dwell-counter width function and output polarity
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_decoder_pkg;

    // FSM state encodings (kept as plain constants for legacy compatibility)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    // Width of a counter that must hold values 0..dwell-1 (at least 1 bit).
    function automatic int dwell_cnt_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

    // Map a logical "active" bit onto the physical output level.
    function automatic logic apply_polarity(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_decoder_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Combinational SEL_W -> 2**SEL_W one-hot (or one-cold)
//               decoder. Shared by the registered scan decoder and the legacy
//               3-to-8 decoder.
// Ports       : sel  - select index
//               dout - decoded vector, bit sel active, others inactive
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [SEL_W-1:0]      sel,
    output logic [(1<<SEL_W)-1:0] dout
);

    localparam int OUT_W = 1 << SEL_W;

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign dout[i] = apply_polarity(sel == SEL_W'(i), ACTIVE_LOW);
    end

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Registered SEL_W-to-2**SEL_W one-hot decoder with a direct
//               mode (decode a loaded select) and a scan mode (step through
//               every output, holding each for DWELL enabled cycles).
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               en         - global enable (also drives in_ready)
//               mode       - 0 = direct, 1 = scan
//               load       - capture sel_in when in_ready
//               sel_in     - select value / scan start index
//               in_ready   - load acceptance qualifier
//               dout       - registered decoded output
//               out_valid  - dout holds a decoded value
//               cur_sel    - index currently driven on dout
//               wrap       - one-cycle pulse on scan wrap to index 0
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel_in,
    output logic                  in_ready,
    output logic [(1<<SEL_W)-1:0] dout,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int              OUT_W      = 1 << SEL_W;
    localparam int              CNT_W      = dwell_cnt_width(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST  = {SEL_W{1'b1}};
    localparam logic            POL        = (ACTIVE_LOW != 0);

    logic [1:0]       state_q,     state_d;
    logic [SEL_W-1:0] cur_sel_q,   cur_sel_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [OUT_W-1:0] dout_q,      dout_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q,      wrap_d;
    logic [OUT_W-1:0] dec_out;

    assign in_ready = en;

    // Decode the next-cycle index so the registered output lines up with cur_sel.
    onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (POL)
    ) u_dec (
        .sel  (cur_sel_d),
        .dout (dec_out)
    );

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        cnt_d       = cnt_q;
        wrap_d      = 1'b0;
        out_valid_d = 1'b0;

        // With en low everything but the visible outputs is frozen.
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (mode) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        if (load) begin
                            cur_sel_d = sel_in;
                        end
                    end else if (load) begin
                        state_d   = ST_DIRECT;
                        cur_sel_d = sel_in;
                    end
                end
                ST_DIRECT: begin
                    if (load) begin
                        cur_sel_d = sel_in;
                    end
                    // Scan resumes from the frozen index with a fresh dwell.
                    if (mode) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_d = ST_DIRECT;
                        if (load) begin
                            cur_sel_d = sel_in;
                        end
                    end else if (load) begin
                        // Load takes priority over dwell expiry and never pulses wrap.
                        cur_sel_d = sel_in;
                        cnt_d     = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        cur_sel_d = cur_sel_q + 1'b1;
                        wrap_d    = (cur_sel_q == SEL_LAST);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            out_valid_d = (state_d != ST_IDLE);
        end

        dout_d = out_valid_d ? dec_out : {OUT_W{POL}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_sel_q   <= '0;
            cnt_q       <= '0;
            dout_q      <= {OUT_W{POL}};
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign wrap      = wrap_q;

endmodule
`default_nettype wire
